alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Decode/issue stage feeding the ALU: turns a RV32I instruction plus register-file reads into
//  srcA, srcB and the 4-bit ALU_SEL code, with an illegal-op flag. Registered valid/ready
//  pipeline stage between the decoder front end and execute; 2-entry skid buffer so the
//  upstream ready is registered.
// PARAMETERS
//  XLEN     32  datapath width (PC, operands)
//  SKID_EN  1   1: 2-entry skid buffer, registered IN_READY; 0: single stage, IN_READY = !OUT_VALID | OUT_READY
// PORTS
//  CLK        in   1     clock, all state on rising edge
//  RST_N      in   1     reset, asynchronous, active-low
//  FLUSH      in   1     sync clear of all held entries (branch redirect)
//  IN_VALID   in   1     IR/PC/RS*_DATA valid this cycle
//  IN_READY   out  1     stage accepts input this cycle
//  IR         in   32    instruction word
//  PC         in   XLEN  instruction address
//  RS1_DATA   in   XLEN  rs1 read data
//  RS2_DATA   in   XLEN  rs2 read data
//  OUT_VALID  out  1     outputs below valid
//  OUT_READY  in   1     execute consumes output this cycle
//  srcA       out  XLEN  ALU operand A
//  srcB       out  XLEN  ALU operand B
//  ALU_SEL    out  4     ALU op code
//  ILLEGAL    out  1     unsupported opcode/funct, travels with entry
//  OUT_PC     out  XLEN  PC of issued entry
// BEHAVIOUR
//  ALU_SEL codes: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101,
//  sra 1101, or 0110, and 0111, lui_copy 1001.
//  Decode (combinational on input, registered on accept):
//  - OP 0110011: A=RS1, B=RS2, SEL={IR[30],funct3}; IR[30]=1 legal only for funct3 000/101; IR[31],IR[29:25] must be 0.
//  - OP-IMM 0010011: A=RS1, B=sext(IR[31:20]); SEL={funct3==101 ? IR[30] : 0, funct3}.
//    Shifts use B[4:0]=IR[24:20]; funct3 001 needs IR[31:25]=0; funct3 101 needs IR[31:25]=0 or 0100000.
//  - LUI 0110111: A={IR[31:12],12'b0}, B=0, SEL=1001.
//  - AUIPC 0010111: A=PC, B={IR[31:12],12'b0}, SEL=0000.
//  - LOAD 0000011 / STORE 0100011: A=RS1, B=sext(I/S immediate), SEL=0000.
//  - JAL 1101111 / JALR 1100111: A=PC, B=4, SEL=0000 (link value).
//  - Any other opcode/funct: ILLEGAL=1, A=B=0, SEL=0000.
//  Handshake:
//  - Input accepted when IN_VALID & IN_READY.
//  - Output retired when OUT_VALID & OUT_READY.
//  - Output fields stable while OUT_VALID & !OUT_READY.
//  - Latency: accept at edge N -> OUT_VALID high after edge N (1 cycle); no combinational IN->OUT path.
//  Skid states (SKID_EN=1): EMPTY, ONE (main reg valid), FULL (main + skid valid).
//  - EMPTY: accept -> ONE.
//  - ONE: accept & !retire -> FULL; retire & !accept -> EMPTY; accept & retire -> ONE (new data).
//  - FULL: IN_READY=0; retire -> ONE, skid entry moves to main reg.
//  - IN_READY = (state != FULL), registered.
//  - Simultaneous accept+retire in ONE: no bubble; back-to-back throughput 1/cycle.
//  FLUSH: next state EMPTY, OUT_VALID=0; input offered in the same cycle is dropped (IN_READY still
//  reported but the accept is discarded).
//  Reset (RST_N=0, any time incl. mid-transfer): state EMPTY, OUT_VALID=0, IN_READY=1 after release,
//  srcA=srcB=OUT_PC=0, ALU_SEL=0000, ILLEGAL=0.
// TESTING
//  1. IR=0x002081B3 (add), RS1=5, RS2=7 -> next cycle OUT_VALID=1, A=5, B=7, SEL=0000.
//  2. IR=0x402081B3 (sub) -> SEL=1000; IR=0x4030D293 (srai x5,x1,3) -> SEL=1101, B[4:0]=3.
//  3. IR=0x40000093 (addi x1,x0,0x400) -> SEL=0000 (not sub), B=0x400; IR=0xFFF00093 -> B=0xFFFFFFFF.
//  4. IR=0x123450B7 (lui) -> A=0x12345000, SEL=1001; IR=0xFFFFFFFF -> ILLEGAL=1.
//  5. OUT_READY=0, 3 inputs offered -> 2 held, IN_READY=0; then OUT_READY=1 -> drained in order, no loss/dup.
//  6. FLUSH with FULL -> OUT_VALID=0 next cycle; RST_N low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_issue_if.sv
// Handshake and operand bus between decoder front end, the issue stage and execute.
// master = the side that offers instructions and consumes operands; slave = the issue stage.
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            IN_VALID;
    logic            IN_READY;
    logic [31:0]     IR;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] RS1_DATA;
    logic [XLEN-1:0] RS2_DATA;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [3:0]      ALU_SEL;
    logic            ILLEGAL;
    logic [XLEN-1:0] OUT_PC;

    modport master (
        output IN_VALID, IR, PC, RS1_DATA, RS2_DATA, OUT_READY,
        input  IN_READY, OUT_VALID, srcA, srcB, ALU_SEL, ILLEGAL, OUT_PC
    );

    modport slave (
        input  IN_VALID, IR, PC, RS1_DATA, RS2_DATA, OUT_READY,
        output IN_READY, OUT_VALID, srcA, srcB, ALU_SEL, ILLEGAL, OUT_PC
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: builds ALU operands and op code, then holds them in a
// valid/ready register stage with an optional 2-entry skid buffer.
module alu_issue_stage #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    alu_issue_if.slave  s_if
);
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] pc;
        logic [3:0]      sel;
        logic            ill;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    entry_t          r_main;
    entry_t          r_skid;
    entry_t          w_dec;
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_retire;

    assign w_opc   = s_if.IR[6:0];
    assign w_f3    = s_if.IR[14:12];
    assign w_f7    = s_if.IR[31:25];
    assign w_imm_i = XLEN'($signed(s_if.IR[31:20]));
    assign w_imm_s = XLEN'($signed({s_if.IR[31:25], s_if.IR[11:7]}));
    assign w_imm_u = XLEN'($signed({s_if.IR[31:12], 12'b0}));
    assign w_shamt = XLEN'(s_if.IR[24:20]);

    // Illegal encodings leave the all-zero default and only raise the flag.
    always_comb begin
        w_dec    = '0;
        w_dec.pc = s_if.PC;
        case (w_opc)
            7'b0110011: begin
                if (!s_if.IR[31] && (s_if.IR[29:25] == 5'b0) &&
                    (!s_if.IR[30] || w_f3 == 3'b000 || w_f3 == 3'b101)) begin
                    w_dec.a   = s_if.RS1_DATA;
                    w_dec.b   = s_if.RS2_DATA;
                    w_dec.sel = {s_if.IR[30], w_f3};
                end else begin
                    w_dec.ill = 1'b1;
                end
            end
            7'b0010011: begin
                case (w_f3)
                    3'b001: begin
                        if (w_f7 == 7'b0000000) begin
                            w_dec.a   = s_if.RS1_DATA;
                            w_dec.b   = w_shamt;
                            w_dec.sel = 4'b0001;
                        end else begin
                            w_dec.ill = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) begin
                            w_dec.a   = s_if.RS1_DATA;
                            w_dec.b   = w_shamt;
                            w_dec.sel = {s_if.IR[30], 3'b101};
                        end else begin
                            w_dec.ill = 1'b1;
                        end
                    end
                    default: begin
                        w_dec.a   = s_if.RS1_DATA;
                        w_dec.b   = w_imm_i;
                        w_dec.sel = {1'b0, w_f3};
                    end
                endcase
            end
            7'b0110111: begin
                w_dec.a   = w_imm_u;
                w_dec.sel = 4'b1001;
            end
            7'b0010111: begin
                w_dec.a = s_if.PC;
                w_dec.b = w_imm_u;
            end
            7'b0000011: begin
                w_dec.a = s_if.RS1_DATA;
                w_dec.b = w_imm_i;
            end
            7'b0100011: begin
                w_dec.a = s_if.RS1_DATA;
                w_dec.b = w_imm_s;
            end
            7'b1101111, 7'b1100111: begin
                w_dec.a = s_if.PC;
                w_dec.b = XLEN'(4);
            end
            default: w_dec.ill = 1'b1;
        endcase
    end

    // Without the skid buffer the ready path is combinational; the FSM never reaches FULL then.
    assign w_in_ready = SKID_EN ? r_in_ready : (!r_out_valid || s_if.OUT_READY);
    assign w_accept   = s_if.IN_VALID && w_in_ready;
    assign w_retire   = r_out_valid && s_if.OUT_READY;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
        end else if (i_flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= w_dec;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_retire) begin
                        r_main <= w_dec;
                    end else if (w_accept) begin
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_retire) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_retire) begin
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Skid copy is only read in FULL, which is entered exactly when it was just written.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_skid <= w_dec;
        end
    end

    assign s_if.IN_READY  = w_in_ready;
    assign s_if.OUT_VALID = r_out_valid;
    assign s_if.srcA      = r_main.a;
    assign s_if.srcB      = r_main.b;
    assign s_if.ALU_SEL   = r_main.sel;
    assign s_if.ILLEGAL   = r_main.ill;
    assign s_if.OUT_PC    = r_main.pc;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, skid stall/drain, flush and async reset.
module tb_alu_issue_stage;
    logic clk;
    logic rst_n;
    logic flush;
    int   total;
    int   bad;

    alu_issue_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .s_if    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.IN_VALID = 1'b1;
        bus.IR       = ir;
        bus.PC       = pc;
        bus.RS1_DATA = rs1;
        bus.RS2_DATA = rs2;
    endtask

    task automatic send(input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        drive(ir, pc, rs1, rs2);
        step();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sel, input logic ill);
        chk({tag, ".vld"}, 32'(bus.OUT_VALID), 32'd1);
        chk({tag, ".A"},   bus.srcA, a);
        chk({tag, ".B"},   bus.srcB, b);
        chk({tag, ".SEL"}, 32'(bus.ALU_SEL), 32'(sel));
        chk({tag, ".ILL"}, 32'(bus.ILLEGAL), 32'(ill));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".vld"}, 32'(bus.OUT_VALID), 32'd0);
        chk({tag, ".A"},   bus.srcA, 32'd0);
        chk({tag, ".B"},   bus.srcB, 32'd0);
        chk({tag, ".SEL"}, 32'(bus.ALU_SEL), 32'd0);
        chk({tag, ".ILL"}, 32'(bus.ILLEGAL), 32'd0);
        chk({tag, ".PC"},  bus.OUT_PC, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.IR        = 32'h0;
        bus.PC        = 32'h0;
        bus.RS1_DATA  = 32'h0;
        bus.RS2_DATA  = 32'h0;
        bus.OUT_READY = 1'b1;

        step();
        step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();
        chk("reset.in_ready", 32'(bus.IN_READY), 32'd1);
        chk("reset.vld_idle", 32'(bus.OUT_VALID), 32'd0);

        // Decode vectors, streamed back to back with OUT_READY=1
        send(32'h002081B3, 32'h0000_0100, 32'd5, 32'd7);
        chk_out("add", 32'd5, 32'd7, 4'b0000, 1'b0);
        chk("add.pc", bus.OUT_PC, 32'h0000_0100);
        send(32'h402081B3, 32'h0000_0104, 32'd9, 32'd3);
        chk_out("sub", 32'd9, 32'd3, 4'b1000, 1'b0);
        chk("sub.pc", bus.OUT_PC, 32'h0000_0104);
        send(32'h4030D293, 32'h0000_0108, 32'h8000_0000, 32'd0);
        chk("srai.vld", 32'(bus.OUT_VALID), 32'd1);
        chk("srai.A", bus.srcA, 32'h8000_0000);
        chk("srai.SEL", 32'(bus.ALU_SEL), 32'b1101);
        chk("srai.shamt", 32'(bus.srcB[4:0]), 32'd3);
        send(32'h40000093, 32'h0000_010C, 32'd0, 32'd0);
        chk_out("addi400", 32'd0, 32'h0000_0400, 4'b0000, 1'b0);
        send(32'hFFF00093, 32'h0000_0110, 32'd1, 32'd0);
        chk_out("addi_m1", 32'd1, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        send(32'h123450B7, 32'h0000_0114, 32'd77, 32'd88);
        chk_out("lui", 32'h1234_5000, 32'd0, 4'b1001, 1'b0);
        send(32'hFFFFFFFF, 32'h0000_0118, 32'd77, 32'd88);
        chk_out("illegal_op", 32'd0, 32'd0, 4'b0000, 1'b1);
        send(32'h402091B3, 32'h0000_011C, 32'd77, 32'd88);
        chk_out("illegal_sll30", 32'd0, 32'd0, 4'b0000, 1'b1);
        send(32'h12345097, 32'h0000_2000, 32'd1, 32'd2);
        chk_out("auipc", 32'h0000_2000, 32'h1234_5000, 4'b0000, 1'b0);
        send(32'hFE20AE23, 32'h0000_2004, 32'h0000_1000, 32'd2);
        chk_out("sw", 32'h0000_1000, 32'hFFFF_FFFC, 4'b0000, 1'b0);
        send(32'h0000006F, 32'h0000_3000, 32'd5, 32'd6);
        chk_out("jal", 32'h0000_3000, 32'd4, 4'b0000, 1'b0);
        chk("jal.pc", bus.OUT_PC, 32'h0000_3000);
        step();
        chk("drain.vld", 32'(bus.OUT_VALID), 32'd0);

        // Stall: three offered, two held, then drain in order
        bus.OUT_READY = 1'b0;
        drive(32'h002081B3, 32'h0000_0400, 32'd11, 32'd1);
        step();
        chk("stall1.A", bus.srcA, 32'd11);
        chk("stall1.rdy", 32'(bus.IN_READY), 32'd1);
        drive(32'h002081B3, 32'h0000_0404, 32'd22, 32'd2);
        step();
        chk("stall2.A", bus.srcA, 32'd11);
        chk("stall2.rdy", 32'(bus.IN_READY), 32'd0);
        drive(32'h002081B3, 32'h0000_0408, 32'd33, 32'd3);
        step();
        chk("stall3.A", bus.srcA, 32'd11);
        chk("stall3.vld", 32'(bus.OUT_VALID), 32'd1);
        chk("stall3.rdy", 32'(bus.IN_READY), 32'd0);
        bus.OUT_READY = 1'b1;
        step();
        chk("drain2.A", bus.srcA, 32'd22);
        chk("drain2.pc", bus.OUT_PC, 32'h0000_0404);
        chk("drain2.rdy", 32'(bus.IN_READY), 32'd1);
        step();
        bus.IN_VALID = 1'b0;
        chk("drain3.A", bus.srcA, 32'd33);
        chk("drain3.B", bus.srcB, 32'd3);
        chk("drain3.vld", 32'(bus.OUT_VALID), 32'd1);
        step();
        chk("drain_end.vld", 32'(bus.OUT_VALID), 32'd0);

        // Flush while FULL; offered input in the flush cycle is dropped
        bus.OUT_READY = 1'b0;
        send(32'h002081B3, 32'h0000_0500, 32'd44, 32'd4);
        send(32'h002081B3, 32'h0000_0504, 32'd55, 32'd5);
        chk("full.rdy", 32'(bus.IN_READY), 32'd0);
        flush = 1'b1;
        drive(32'h002081B3, 32'h0000_0508, 32'd66, 32'd6);
        step();
        flush = 1'b0;
        bus.IN_VALID = 1'b0;
        chk("flush.vld", 32'(bus.OUT_VALID), 32'd0);
        chk("flush.rdy", 32'(bus.IN_READY), 32'd1);
        flush = 1'b1;
        drive(32'h002081B3, 32'h0000_050C, 32'd67, 32'd6);
        step();
        flush = 1'b0;
        bus.IN_VALID = 1'b0;
        step();
        chk("flush_drop.vld", 32'(bus.OUT_VALID), 32'd0);
        send(32'h002081B3, 32'h0000_0510, 32'd77, 32'd7);
        chk("post_flush.A", bus.srcA, 32'd77);
        chk("post_flush.vld", 32'(bus.OUT_VALID), 32'd1);

        // Asynchronous reset while stalled and FULL
        send(32'h002081B3, 32'h0000_0514, 32'd88, 32'd8);
        chk("prereset.rdy", 32'(bus.IN_READY), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        step();
        rst_n = 1'b1;
        bus.OUT_READY = 1'b1;
        step();
        chk("post_reset.rdy", 32'(bus.IN_READY), 32'd1);
        chk("post_reset.vld", 32'(bus.OUT_VALID), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
